// File: rtl/reg_bank.sv
// reg_bank: W-entry, N-bit register bank with one write port, a combinational
// read port, per-entry valid flags with a live count, and a sequential clear
// engine that walks every entry once. Entry 0 is the most-significant slice
// of q and the most-significant bit of valid.
module reg_bank #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [$clog2(W)-1:0]  waddr,
  input  logic [N-1:0]          wdata,
  input  logic [$clog2(W)-1:0]  raddr,
  output logic [N-1:0]          rdata,
  input  logic                  clr,
  output logic                  busy,
  output logic [W-1:0]          valid,
  output logic [$clog2(W):0]    count,
  output logic [W*N-1:0]        q
);

  localparam int unsigned AW = $clog2(W);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] LAST = AW'(W - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ptr;
  logic [N-1:0]  mem [W];
  logic [W-1:0]  ent_vld;
  logic [CW-1:0] cnt;

  logic          wr_en;
  logic          clr_en;
  logic          clr_start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: clear starts from IDLE, ends after the last entry
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr) state_nxt = CLEAR;
      CLEAR:   if (ptr == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/control decode: clear beats write in IDLE; CLEAR drops writes
  always_comb begin
    wr_en     = 1'b0;
    clr_en    = 1'b0;
    clr_start = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        clr_start = clr;
        wr_en     = we && !clr;
      end
      CLEAR: begin
        clr_en = 1'b1;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // Clear pointer: reset to 0 at start, advance once per CLEAR cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr_start) begin
      ptr <= '0;
    end else if (clr_en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
    end
  end

  // Entry storage and valid flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(W); k++) begin
        mem[k] <= '0;
      end
      ent_vld <= '0;
    end else if (wr_en) begin
      mem[waddr]     <= wdata;
      ent_vld[waddr] <= 1'b1;
    end else if (clr_en) begin
      mem[ptr]     <= '0;
      ent_vld[ptr] <= 1'b0;
    end
  end

  // Valid count tracks popcount of flags by edge-wise inc/dec
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (wr_en && !ent_vld[waddr]) begin
      cnt <= cnt + CW'(1);
    end else if (clr_en && ent_vld[ptr]) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign count = cnt;
  assign rdata = mem[raddr];

  // Pack entries and flags with entry 0 in the most-significant position
  for (genvar k = 0; k < int'(W); k++) begin : g_pack
    assign q[(W-k)*N-1 -: N] = mem[k];
    assign valid[W-1-k]      = ent_vld[k];
  end

endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank with W=8, N=16.
module tb_reg_bank;

  localparam int W = 8;
  localparam int N = 16;

  logic          clk;
  logic          rst;
  logic          we;
  logic [2:0]    waddr;
  logic [15:0]   wdata;
  logic [2:0]    raddr;
  logic [15:0]   rdata;
  logic          clr;
  logic          busy;
  logic [7:0]    valid;
  logic [3:0]    count;
  logic [127:0]  q;

  int total = 0;
  int bad   = 0;

  reg_bank #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .clr(clr), .busy(busy),
    .valid(valid), .count(count), .q(q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ent(input logic [127:0] qq, input int k);
    return qq[(8-k)*16-1 -: 16];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; we = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    @(negedge clk);
    we = 1'b1; waddr = 3'(a); wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic fill();
    for (int k = 0; k < W; k++) wr(k, 16'h1000 + 16'(k));
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; clr = 1'b0; waddr = '0; wdata = '0; raddr = 3'd4;
    #12;
    total++; if (q !== 128'h0) begin bad++; $display("FAIL reset_q got %h want 0", q); end
    total++; if (valid !== 8'h00) begin bad++; $display("FAIL reset_valid got %h want 00", valid); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got %0d want 0", count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ends();
    wr(0, 16'hAAAA);
    wr(7, 16'h5555);
    total++; if (q[127:112] !== 16'hAAAA) begin bad++; $display("FAIL ends_q_msb got %h want aaaa", q[127:112]); end
    total++; if (q[15:0] !== 16'h5555) begin bad++; $display("FAIL ends_q_lsb got %h want 5555", q[15:0]); end
    total++; if (valid !== 8'b1000_0001) begin bad++; $display("FAIL ends_valid got %b want 10000001", valid); end
    total++; if (count !== 4'd2) begin bad++; $display("FAIL ends_count got %0d want 2", count); end
  endtask

  task automatic test_read_write();
    do_reset();
    @(negedge clk);
    raddr = 3'd3; we = 1'b1; waddr = 3'd3; wdata = 16'h1234;
    #1;
    total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL rw_before got %h want 0000", rdata); end
    @(negedge clk);
    we = 1'b0;
    total++; if (rdata !== 16'h1234) begin bad++; $display("FAIL rw_after got %h want 1234", rdata); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL rw_count1 got %0d want 1", count); end
    wr(3, 16'h4321);
    total++; if (rdata !== 16'h4321) begin bad++; $display("FAIL rw_rewrite got %h want 4321", rdata); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL rw_count_same got %0d want 1", count); end
    total++; if (valid !== 8'b0001_0000) begin bad++; $display("FAIL rw_valid got %b want 00010000", valid); end
  endtask

  task automatic test_fill_clear();
    do_reset();
    fill();
    total++; if (count !== 4'd8) begin bad++; $display("FAIL fill_count got %0d want 8", count); end
    total++; if (valid !== 8'hFF) begin bad++; $display("FAIL fill_valid got %h want ff", valid); end
    clr = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 16'hFFFF; raddr = 3'd5;
    @(negedge clk);
    clr = 1'b0; we = 1'b0;
    total++; if (ent(q, 2) !== 16'h1002) begin bad++; $display("FAIL clr_drop_write got %h want 1002", ent(q, 2)); end
    for (int i = 0; i < W; i++) begin
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL clr_busy[%0d] got %b want 1", i, busy); end
      total++; if (count !== 4'(8 - i)) begin bad++; $display("FAIL clr_count[%0d] got %0d want %0d", i, count, 8 - i); end
      if (i <= 5) begin
        total++; if (rdata !== 16'h1005) begin bad++; $display("FAIL clr_keep5[%0d] got %h want 1005", i, rdata); end
      end else begin
        total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL clr_gone5[%0d] got %h want 0000", i, rdata); end
      end
      @(negedge clk);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL clr_done_busy got %b want 0", busy); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL clr_done_count got %0d want 0", count); end
    total++; if (valid !== 8'h00) begin bad++; $display("FAIL clr_done_valid got %h want 00", valid); end
    total++; if (q !== 128'h0) begin bad++; $display("FAIL clr_done_q got %h want 0", q); end
  endtask

  task automatic test_we_during_clear();
    wr(1, 16'h0011);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < W; i++) begin
      we    = (i == 3);
      waddr = 3'd0;
      wdata = 16'hBEEF;
      clr   = (i == 4);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL wdc_busy[%0d] got %b want 1", i, busy); end
      @(negedge clk);
    end
    we = 1'b0; clr = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL wdc_no_restart got %b want 0", busy); end
    total++; if (ent(q, 0) !== 16'h0000) begin bad++; $display("FAIL wdc_entry0 got %h want 0000", ent(q, 0)); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL wdc_count got %0d want 0", count); end
    we = 1'b1; waddr = 3'd0; wdata = 16'hBEEF;
    @(negedge clk);
    we = 1'b0;
    total++; if (ent(q, 0) !== 16'hBEEF) begin bad++; $display("FAIL post_wr_entry0 got %h want beef", ent(q, 0)); end
    total++; if (count !== 4'd1) begin bad++; $display("FAIL post_wr_count got %0d want 1", count); end
    total++; if (valid !== 8'h80) begin bad++; $display("FAIL post_wr_valid got %h want 80", valid); end
  endtask

  task automatic test_reset_mid_clear();
    do_reset();
    fill();
    raddr = 3'd6;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (count !== 4'd6) begin bad++; $display("FAIL rmc_pre_count got %0d want 6", count); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmc_busy got %b want 0", busy); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL rmc_count got %0d want 0", count); end
    total++; if (valid !== 8'h00) begin bad++; $display("FAIL rmc_valid got %h want 00", valid); end
    total++; if (q !== 128'h0) begin bad++; $display("FAIL rmc_q got %h want 0", q); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL rmc_rdata got %h want 0", rdata); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmc_no_resume[%0d] got %b want 0", i, busy); end
    end
    wr(4, 16'h00C4);
    total++; if (count !== 4'd1) begin bad++; $display("FAIL rmc_wr_count got %0d want 1", count); end
  endtask

  initial begin
    test_reset();
    test_ends();
    test_read_write();
    test_fill_clear();
    test_we_during_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
